// File: rtl/deser400_arbiter.sv
// Round-robin merge of four deser400 channel pairs into one 16-bit FIFO write stream.
// Each accepted event is buffered (2 deep per channel) and sent as header, A word, B word.
module deser400_arbiter #(
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic        clk160,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic [3:0]  ch_write,
    input  logic [63:0] ch_par_a,
    input  logic [63:0] ch_par_b,
    input  logic        fifo_full,
    output logic [15:0] dout,
    output logic        dout_wr,
    output logic        busy,
    output logic [3:0]  overflow,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {StIdle, StHdr, StWa, StWb} state_e;

    state_e      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_grant_q;
    logic [15:0] dout_q;

    logic [1:0]  cnt_q [4];
    logic [3:0]  rd_ptr_q;
    logic [3:0]  wr_ptr_q;
    logic [7:0]  seq_q [4];
    logic [7:0]  ent_seq_q [4][2];
    logic [15:0] ent_a_q [4][2];
    logic [15:0] ent_b_q [4][2];

    logic [3:0]  overflow_q;
    logic [7:0]  drop_count_q;

    logic [3:0]  nonempty;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [3:0]  drop;
    logic [1:0]  next_ch;
    logic [2:0]  drop_sum;
    logic [8:0]  drop_total;
    logic [7:0]  head_seq;
    logic [15:0] head_a;
    logic [15:0] head_b;

    // Pop is evaluated before the full check, so a write on the draining channel is accepted.
    always_comb begin
        nonempty = '0;
        pop      = '0;
        drop     = '0;
        push     = '0;
        for (int i = 0; i < 4; i++) begin
            nonempty[i] = (cnt_q[i] != 2'd0);
            pop[i]      = (state_q == StWb) && !fifo_full && (grant_q == 2'(i));
            drop[i]     = ch_write[i] && enable && (cnt_q[i] == 2'd2) && !pop[i];
            push[i]     = ch_write[i] && enable && !drop[i];
        end
    end

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < 4; i++) begin
            drop_sum = drop_sum + {2'b00, drop[i]};
        end
        drop_total = {1'b0, drop_count_q} + {6'b000000, drop_sum};
    end

    // First non-empty channel searching from last_grant + 1.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        next_ch = last_grant_q;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && nonempty[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    assign head_seq = ent_seq_q[next_ch][rd_ptr_q[next_ch]];
    assign head_a   = ent_a_q[grant_q][rd_ptr_q[grant_q]];
    assign head_b   = ent_b_q[grant_q][rd_ptr_q[grant_q]];

    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                seq_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= ~wr_ptr_q[i];
                    seq_q[i]    <= seq_q[i] + 8'd1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= ~rd_ptr_q[i];
                end
                cnt_q[i] <= cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk160) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                ent_seq_q[i][wr_ptr_q[i]] <= seq_q[i];
                ent_a_q[i][wr_ptr_q[i]]   <= ch_par_a[16*i +: 16];
                ent_b_q[i][wr_ptr_q[i]]   <= ch_par_b[16*i +: 16];
            end
        end
    end

    // A clear in the same cycle as a drop wins, and that drop is forgotten.
    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            overflow_q   <= '0;
            drop_count_q <= '0;
        end else if (clear) begin
            overflow_q   <= '0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_q | drop;
            drop_count_q <= drop_total[8] ? 8'hFF : drop_total[7:0];
        end
    end

    // dout holds the word pending for the current state; it advances only once written.
    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= 2'd3;
            dout_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|nonempty) begin
                        grant_q <= next_ch;
                        dout_q  <= {HDR_TAG, next_ch, 2'b00, head_seq};
                        state_q <= StHdr;
                    end
                end
                StHdr: begin
                    if (!fifo_full) begin
                        dout_q  <= head_a;
                        state_q <= StWa;
                    end
                end
                StWa: begin
                    if (!fifo_full) begin
                        dout_q  <= head_b;
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    if (!fifo_full) begin
                        last_grant_q <= grant_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write strobe qualifies the registered word with this cycle's fifo_full.
    assign dout       = dout_q;
    assign dout_wr    = (state_q != StIdle) && !fifo_full;
    assign busy       = (state_q != StIdle) || (|nonempty);
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_deser400_arbiter.sv
// Directed bench for deser400_arbiter: packet-level model compared every cycle,
// plus hand-computed literal expectations per scenario.
module tb_deser400_arbiter;

    logic        clk160 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic        fifo_full = 1'b0;
    logic [3:0]  ch_write = '0;
    logic [63:0] ch_par_a = '0;
    logic [63:0] ch_par_b = '0;
    logic [15:0] dout;
    logic        dout_wr;
    logic        busy;
    logic [3:0]  overflow;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;
    int cycle_no = 0;
    logic [15:0] wlog[$];
    int          wlog_cyc[$];

    // Model: per-channel event queues and one packet in flight.
    bit [39:0] mq [4][$];
    bit [7:0]  m_seq [4];
    bit [15:0] m_words [3];
    bit        m_busy;
    int        m_idx;
    int        m_ch;
    int        m_last;
    bit [3:0]  m_ovf;
    int        m_drops;

    deser400_arbiter dut (
        .clk160     (clk160),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .ch_write   (ch_write),
        .ch_par_a   (ch_par_a),
        .ch_par_b   (ch_par_b),
        .fifo_full  (fifo_full),
        .dout       (dout),
        .dout_wr    (dout_wr),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial forever #5 clk160 = ~clk160;

    always @(posedge clk160) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_seq[i] = 8'd0;
        end
        m_busy  = 1'b0;
        m_idx   = 0;
        m_ch    = 0;
        m_last  = 3;
        m_ovf   = 4'd0;
        m_drops = 0;
    endtask

    task automatic model_step();
        int nd;
        bit [3:0] dmask;
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (!m_busy && mq[c].size() > 0) begin
                    bit [39:0] e;
                    e = mq[c][0];
                    m_words[0] = {4'hA, 2'(c), 2'b00, e[39:32]};
                    m_words[1] = e[31:16];
                    m_words[2] = e[15:0];
                    m_busy = 1'b1;
                    m_idx  = 0;
                    m_ch   = c;
                end
            end
        end else if (!fifo_full) begin
            m_idx++;
            if (m_idx == 3) begin
                void'(mq[m_ch].pop_front());
                m_last = m_ch;
                m_busy = 1'b0;
            end
        end
        nd = 0;
        dmask = '0;
        for (int i = 0; i < 4; i++) begin
            if (ch_write[i] && enable) begin
                if (mq[i].size() == 2) begin
                    nd++;
                    dmask[i] = 1'b1;
                end else begin
                    mq[i].push_back({m_seq[i], ch_par_a[16*i +: 16], ch_par_b[16*i +: 16]});
                    m_seq[i] = m_seq[i] + 8'd1;
                end
            end
        end
        if (clear) begin
            m_ovf = '0;
            m_drops = 0;
        end else begin
            m_ovf = m_ovf | dmask;
            m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
        end
    endtask

    always @(negedge clk160) begin
        if (reset) begin
            model_reset();
            check("reset_dout", 32'(dout), 32'd0);
            check("reset_dout_wr", 32'(dout_wr), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_overflow", 32'(overflow), 32'd0);
            check("reset_drop_count", 32'(drop_count), 32'd0);
        end else begin
            bit exp_wr;
            bit any_q;
            any_q = 1'b0;
            for (int i = 0; i < 4; i++) if (mq[i].size() > 0) any_q = 1'b1;
            exp_wr = m_busy && !fifo_full;
            check("dout_wr", 32'(dout_wr), 32'(exp_wr));
            if (exp_wr) check("dout", 32'(dout), 32'(m_words[m_idx]));
            check("busy", 32'(busy), 32'(m_busy || any_q));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            if (dout_wr) begin
                wlog.push_back(dout);
                wlog_cyc.push_back(cycle_no);
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    task automatic idle(input int n);
        ch_write = '0;
        repeat (n) tick();
    endtask

    task automatic set_ev(input logic [3:0] w, input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            ch_par_a[16*i +: 16] = a;
            ch_par_b[16*i +: 16] = b;
        end
        ch_write = w;
        tick();
        ch_write = '0;
    endtask

    task automatic do_reset();
        ch_write = '0;
        fifo_full = 1'b0;
        clear = 1'b0;
        enable = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wlog.delete();
        wlog_cyc.delete();
    endtask

    initial begin
        int c0;
        #2;
        do_reset();

        // Single event on channel 2.
        c0 = cycle_no;
        set_ev(4'b0100, 16'h1234, 16'h5678);
        idle(6);
        check("t1_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("t1_hdr", 32'(wlog[0]), 32'hA800);
            check("t1_a", 32'(wlog[1]), 32'h1234);
            check("t1_b", 32'(wlog[2]), 32'h5678);
            check("t1_hdr_cycle", 32'(wlog_cyc[0] - c0), 32'd2);
            check("t1_b_cycle", 32'(wlog_cyc[2] - c0), 32'd4);
        end
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Strobes ignored while enable is low.
        wlog.delete();
        wlog_cyc.delete();
        enable = 1'b0;
        set_ev(4'b0001, 16'hDEAD, 16'hBEEF);
        idle(5);
        enable = 1'b1;
        check("en_ignored", 32'(wlog.size()), 32'd0);

        // Simultaneous events on all channels.
        do_reset();
        c0 = cycle_no;
        set_ev(4'b1111, 16'h0F0F, 16'hF0F0);
        idle(18);
        check("t2_nwrites", 32'(wlog.size()), 32'd12);
        if (wlog.size() == 12) begin
            check("t2_hdr0", 32'(wlog[0]), 32'hA000);
            check("t2_hdr1", 32'(wlog[3]), 32'hA400);
            check("t2_hdr2", 32'(wlog[6]), 32'hA800);
            check("t2_hdr3", 32'(wlog[9]), 32'hAC00);
            check("t2_last_cycle", 32'(wlog_cyc[11] - c0), 32'd16);
        end
        check("t2_overflow", 32'(overflow), 32'd0);

        // Backpressure during WA.
        do_reset();
        c0 = cycle_no;
        set_ev(4'b0010, 16'hABCD, 16'hEF01);
        tick();
        tick();
        fifo_full = 1'b1;
        repeat (5) tick();
        fifo_full = 1'b0;
        idle(4);
        check("t3_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("t3_hdr", 32'(wlog[0]), 32'hA400);
            check("t3_a", 32'(wlog[1]), 32'hABCD);
            check("t3_b", 32'(wlog[2]), 32'hEF01);
            check("t3_a_cycle", 32'(wlog_cyc[1] - c0), 32'd8);
            check("t3_b_cycle", 32'(wlog_cyc[2] - c0), 32'd9);
        end

        // Overflow on channel 1 while the FIFO is full.
        do_reset();
        fifo_full = 1'b1;
        set_ev(4'b0010, 16'h0001, 16'h0002);
        tick();
        set_ev(4'b0010, 16'h0003, 16'h0004);
        tick();
        set_ev(4'b0010, 16'h0005, 16'h0006);
        check("t4_overflow", 32'(overflow), 32'h2);
        check("t4_drop_count", 32'(drop_count), 32'd1);
        fifo_full = 1'b0;
        idle(12);
        check("t4_nwrites", 32'(wlog.size()), 32'd6);
        if (wlog.size() == 6) begin
            check("t4_hdr0", 32'(wlog[0]), 32'hA400);
            check("t4_hdr1", 32'(wlog[3]), 32'hA401);
            check("t4_a1", 32'(wlog[4]), 32'h0003);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_overflow", 32'(overflow), 32'd0);
        check("t4_clr_drop_count", 32'(drop_count), 32'd0);

        // Sequence wrap on channel 3, then drop_count saturation.
        do_reset();
        repeat (256) begin
            set_ev(4'b1000, 16'h3333, 16'h4444);
            idle(4);
        end
        set_ev(4'b1000, 16'h5555, 16'h6666);
        idle(6);
        check("t5_nwrites", 32'(wlog.size()), 32'd771);
        if (wlog.size() == 771) begin
            check("t5_hdr256", 32'(wlog[765]), 32'hACFF);
            check("t5_hdr257", 32'(wlog[768]), 32'hAC00);
        end
        fifo_full = 1'b1;
        ch_write = 4'b1111;
        repeat (80) tick();
        ch_write = '0;
        check("t5_drop_sat", 32'(drop_count), 32'd255);
        check("t5_overflow_all", 32'(overflow), 32'hF);
        fifo_full = 1'b0;
        idle(40);
        check("t5_drained", 32'(busy), 32'd0);

        // Reset in the middle of a packet.
        do_reset();
        set_ev(4'b0001, 16'h1111, 16'h2222);
        tick();
        tick();
        check("t6_wa_writing", 32'(dout_wr), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_dout_wr", 32'(dout_wr), 32'd0);
        check("t6_rst_dout", 32'(dout), 32'd0);
        tick();
        reset = 1'b0;
        check("t6_busy_after", 32'(busy), 32'd0);
        wlog.delete();
        wlog_cyc.delete();
        set_ev(4'b0001, 16'h7777, 16'h8888);
        idle(6);
        check("t6_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) check("t6_hdr", 32'(wlog[0]), 32'hA000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
